// File: rtl/dht11_pkg.sv
// dht11_pkg: shared definitions for the DHT11 responder and its host-side peer.
//   - state_t          : responder FSM state encoding
//   - DHT11_*          : 125 MHz default timing constants (clk cycles)
//   - SYNC_STAGES      : depth of the line input synchronizer
//   - FRAME_BITS       : bits per DHT11 frame
//   - dht11_checksum() : 8-bit wrapping sum of the four data bytes
package dht11_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HOST_LOW = 3'd1,
    DELAY    = 3'd2,
    RESP_L   = 3'd3,
    RESP_H   = 3'd4,
    BIT_L    = 3'd5,
    BIT_H    = 3'd6,
    END_L    = 3'd7
  } state_t;

  localparam int unsigned DHT11_START_MIN  = 125000; // 1 ms
  localparam int unsigned DHT11_RESP_DELAY = 3750;   // 30 us
  localparam int unsigned DHT11_RESP_LOW   = 10000;  // 80 us
  localparam int unsigned DHT11_RESP_HIGH  = 10000;  // 80 us
  localparam int unsigned DHT11_BIT_LOW    = 6250;   // 50 us
  localparam int unsigned DHT11_ZERO_HIGH  = 3250;   // 26 us
  localparam int unsigned DHT11_ONE_HIGH   = 8750;   // 70 us

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned FRAME_BITS  = 40;

  function automatic logic [7:0] dht11_checksum(
    input logic [7:0] hum_int,
    input logic [7:0] hum_dec,
    input logic [7:0] tmp_int,
    input logic [7:0] tmp_dec
  );
    return hum_int + hum_dec + tmp_int + tmp_dec;
  endfunction

endpackage

// File: rtl/dht11_sensor_emulator_if.sv
// dht11_sensor_emulator_if: data and status bundle of the DHT11 responder.
//   humidity, temperature, corrupt_checksum : frame contents (driven by master)
//   busy, start_seen, short_start,
//   frame_done, frame_count                  : responder status (driven by slave)
// modport master : the fixture / bench supplying readings
// modport slave  : the emulator itself
interface dht11_sensor_emulator_if;
  logic [15:0] humidity;
  logic [15:0] temperature;
  logic        corrupt_checksum;
  logic        busy;
  logic        start_seen;
  logic        short_start;
  logic        frame_done;
  logic [7:0]  frame_count;

  modport master (
    output humidity, temperature, corrupt_checksum,
    input  busy, start_seen, short_start, frame_done, frame_count
  );

  modport slave (
    input  humidity, temperature, corrupt_checksum,
    output busy, start_seen, short_start, frame_done, frame_count
  );
endinterface

// File: rtl/dht11_line_sync.sv
// dht11_line_sync: synchronizer bringing the asynchronous open-drain line into clk.
//   clk, rst : clock and synchronous active-high reset
//   line_in  : raw line level
//   line_s   : synchronized line level (resets to 1, the idle pulled-up level)
module dht11_line_sync
  import dht11_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_s
);

  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], line_in};
    end
  end

  assign line_s = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/dht11_sensor_emulator.sv
// dht11_sensor_emulator: responder end of the DHT11 single-wire protocol.
// Waits for a host start pulse, answers with the 80/80 us response and a
// 40-bit frame {hum_int, hum_dec, tmp_int, tmp_dec, checksum}, MSB first.
//   clk, rst  : clock and synchronous active-high reset
//   dht11_io  : open-drain line, driven 0 or released (z), never driven 1
//   bus       : slave side of dht11_sensor_emulator_if (readings in, status out)
module dht11_sensor_emulator
  import dht11_pkg::*;
#(
  parameter int unsigned START_MIN  = DHT11_START_MIN,
  parameter int unsigned RESP_DELAY = DHT11_RESP_DELAY,
  parameter int unsigned RESP_LOW   = DHT11_RESP_LOW,
  parameter int unsigned RESP_HIGH  = DHT11_RESP_HIGH,
  parameter int unsigned BIT_LOW    = DHT11_BIT_LOW,
  parameter int unsigned ZERO_HIGH  = DHT11_ZERO_HIGH,
  parameter int unsigned ONE_HIGH   = DHT11_ONE_HIGH
) (
  input  logic                     clk,
  input  logic                     rst,
  inout  wire                      dht11_io,
  dht11_sensor_emulator_if.slave   bus
);

  state_t      state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [5:0]  bit_idx_reg, bit_idx_next;
  logic [39:0] frame_reg, frame_next;
  logic        drive_low_reg, drive_low_next;
  logic        busy_reg, busy_next;
  logic        start_seen_reg, start_seen_next;
  logic        short_start_reg, short_start_next;
  logic        frame_done_reg, frame_done_next;
  logic [7:0]  frame_count_reg, frame_count_next;
  logic        line_s;
  logic [31:0] high_len;
  logic [7:0]  cks;

  dht11_line_sync u_line_sync (
    .clk     (clk),
    .rst     (rst),
    .line_in (dht11_io),
    .line_s  (line_s)
  );

  // Open drain: pull low or let the external pull-up win.
  assign dht11_io = drive_low_reg ? 1'b0 : 1'bz;

  // The bit currently on the wire is always frame_reg[39]; the frame shifts
  // left after each bit.
  assign high_len = frame_reg[39] ? ONE_HIGH : ZERO_HIGH;

  assign cks = dht11_checksum(bus.humidity[15:8], bus.humidity[7:0],
                              bus.temperature[15:8], bus.temperature[7:0])
               ^ {7'b0, bus.corrupt_checksum};

  function automatic logic phase_end(input logic [31:0] count, input int unsigned len);
    return count == len - 1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      bit_idx_reg     <= '0;
      frame_reg       <= '0;
      drive_low_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      start_seen_reg  <= 1'b0;
      short_start_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      bit_idx_reg     <= bit_idx_next;
      frame_reg       <= frame_next;
      drive_low_reg   <= drive_low_next;
      busy_reg        <= busy_next;
      start_seen_reg  <= start_seen_next;
      short_start_reg <= short_start_next;
      frame_done_reg  <= frame_done_next;
      frame_count_reg <= frame_count_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg + 32'd1;
    bit_idx_next      = bit_idx_reg;
    frame_next        = frame_reg;
    busy_next         = busy_reg;
    start_seen_next   = 1'b0;
    short_start_next  = 1'b0;
    frame_done_next   = 1'b0;
    frame_count_next  = frame_count_reg;

    case (state_reg)
      IDLE: begin
        // After our own low phase ends, line_s still shows the old low for
        // SYNC_STAGES cycles; hold off so that echo is not taken for a host.
        if (cnt_reg < 32'(SYNC_STAGES)) begin
          cnt_next = cnt_reg + 32'd1;
        end else begin
          cnt_next = cnt_reg;
          if (!line_s) begin
            state_next = HOST_LOW;
            cnt_next   = '0;
          end
        end
      end

      HOST_LOW: begin
        if (!line_s) begin
          // Saturate at the threshold; longer pulses need no more resolution.
          cnt_next = (cnt_reg < START_MIN) ? cnt_reg + 32'd1 : cnt_reg;
        end else if (cnt_reg >= START_MIN) begin
          start_seen_next = 1'b1;
          busy_next       = 1'b1;
          frame_next      = {bus.humidity, bus.temperature, cks};
          state_next      = DELAY;
          cnt_next        = '0;
        end else begin
          short_start_next = 1'b1;
          state_next       = IDLE;
          cnt_next         = '0;
        end
      end

      DELAY: begin
        if (phase_end(cnt_reg, RESP_DELAY)) begin
          state_next = RESP_L;
          cnt_next   = '0;
        end
      end

      RESP_L: begin
        if (phase_end(cnt_reg, RESP_LOW)) begin
          state_next = RESP_H;
          cnt_next   = '0;
        end
      end

      RESP_H: begin
        if (phase_end(cnt_reg, RESP_HIGH)) begin
          state_next   = BIT_L;
          cnt_next     = '0;
          bit_idx_next = 6'(FRAME_BITS - 1);
        end
      end

      BIT_L: begin
        if (phase_end(cnt_reg, BIT_LOW)) begin
          state_next = BIT_H;
          cnt_next   = '0;
        end
      end

      BIT_H: begin
        if (cnt_reg == high_len - 32'd1) begin
          cnt_next   = '0;
          frame_next = {frame_reg[38:0], 1'b0};
          if (bit_idx_reg != 6'd0) begin
            bit_idx_next = bit_idx_reg - 6'd1;
            state_next   = BIT_L;
          end else begin
            state_next = END_L;
          end
        end
      end

      END_L: begin
        if (phase_end(cnt_reg, BIT_LOW)) begin
          state_next       = IDLE;
          cnt_next         = '0;
          busy_next        = 1'b0;
          frame_done_next  = 1'b1;
          frame_count_next = frame_count_reg + 8'd1;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    // Registered drive follows the next state, so each low phase begins on
    // the same edge the state is entered and lasts exactly its count.
    drive_low_next = (state_next == RESP_L) || (state_next == BIT_L) ||
                     (state_next == END_L);
  end

  assign bus.busy        = busy_reg;
  assign bus.start_seen  = start_seen_reg;
  assign bus.short_start = short_start_reg;
  assign bus.frame_done  = frame_done_reg;
  assign bus.frame_count = frame_count_reg;

endmodule

// File: tb/tb_dht11_sensor_emulator.sv
// tb_dht11_sensor_emulator: host-side bench for dht11_sensor_emulator with
// scaled-down timings. A waveform model (expected line/status per cycle after
// start_seen) is built from the frame bytes and compared every cycle.
module tb_dht11_sensor_emulator;
  localparam int unsigned T_START = 12;
  localparam int unsigned T_DELAY = 3;
  localparam int unsigned T_RL    = 6;
  localparam int unsigned T_RH    = 6;
  localparam int unsigned T_BL    = 3;
  localparam int unsigned T_ZH    = 2;
  localparam int unsigned T_OH    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic host_low = 1'b0;
  wire  dht11_line;

  pullup (dht11_line);
  assign dht11_line = host_low ? 1'b0 : 1'bz;

  dht11_sensor_emulator_if bus ();

  dht11_sensor_emulator #(
    .START_MIN (T_START), .RESP_DELAY(T_DELAY), .RESP_LOW(T_RL),
    .RESP_HIGH (T_RH), .BIT_LOW(T_BL), .ZERO_HIGH(T_ZH), .ONE_HIGH(T_OH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dht11_io (dht11_line),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  // Per-cycle expectation: {line, busy, frame_done, start_seen, short_start}
  logic [4:0]  exp_q[$];
  int          exp_idx = 0;
  bit          exp_armed = 0;
  bit          exp_active = 0;
  logic [7:0]  model_count = 8'd0;
  logic [39:0] last_decoded = '0;
  int          fd_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic push_run(input logic lvl, input int unsigned len);
    for (int i = 0; i < int'(len); i++) exp_q.push_back({lvl, 1'b1, 1'b0, 1'b0, 1'b0});
  endtask

  // Expected waveform from the start_seen cycle to the frame_done cycle.
  task automatic build_expect(input logic [15:0] hum, input logic [15:0] tmp, input logic cor);
    logic [7:0] b [5];
    int sum;
    b[0] = hum[15:8]; b[1] = hum[7:0]; b[2] = tmp[15:8]; b[3] = tmp[7:0];
    sum = int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[3]);
    b[4] = 8'(sum % 256) ^ {7'b0, cor};
    exp_q.delete();
    push_run(1'b1, T_DELAY);
    exp_q[0] = 5'b11010;
    push_run(1'b0, T_RL);
    push_run(1'b1, T_RH);
    for (int k = 0; k < 5; k++) begin
      for (int j = 7; j >= 0; j--) begin
        push_run(1'b0, T_BL);
        push_run(1'b1, b[k][j] ? T_OH : T_ZH);
      end
    end
    push_run(1'b0, T_BL);
    exp_q.push_back(5'b10100);
  endtask

  // Compare process: checks every cycle of an expected frame and decodes it.
  initial begin : compare
    int run_len;
    int high_runs;
    logic prev_line;
    logic [39:0] decoded;
    logic [4:0] act;
    run_len = 0; high_runs = 0; prev_line = 1'b1; decoded = '0;
    forever begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) fd_seen++;
      if (exp_armed && !exp_active && bus.start_seen === 1'b1) begin
        exp_armed = 0; exp_active = 1; exp_idx = 0;
        run_len = 0; high_runs = 0; prev_line = 1'b1; decoded = '0;
      end
      if (exp_active) begin
        act = {dht11_line, bus.busy, bus.frame_done, bus.start_seen, bus.short_start};
        check("wave", 64'(act), 64'(exp_q[exp_idx]));
        if (dht11_line === 1'b1) begin
          run_len++;
        end else begin
          if (prev_line === 1'b1) begin
            high_runs++;
            // runs 1 and 2 are the delay and response-high phases
            if (high_runs >= 3) decoded = {decoded[38:0], (run_len > int'((T_ZH + T_OH) / 2))};
          end
          run_len = 0;
        end
        prev_line = dht11_line;
        exp_idx++;
        if (exp_idx == exp_q.size()) begin
          model_count = model_count + 8'd1;
          check("frame_count_step", 64'(bus.frame_count), 64'(model_count));
          last_decoded = decoded;
          exp_active = 0;
        end
      end
    end
  end

  task automatic run_frame(input logic [15:0] hum, input logic [15:0] tmp, input logic cor,
                           input int low_len, input bit change_hum, input logic [15:0] new_hum);
    int n;
    bus.humidity = hum; bus.temperature = tmp; bus.corrupt_checksum = cor;
    build_expect(hum, tmp, cor);
    host_low = 1'b1;
    repeat (low_len) @(negedge clk);
    host_low = 1'b0;
    exp_armed = 1;
    n = 0;
    while (!exp_active && n < 12) begin @(negedge clk); n++; end
    check("start_seen_in_time", 64'(n < 12), 64'd1);
    if (n >= 12) begin
      exp_armed = 0;
    end else begin
      if (change_hum) begin
        @(negedge clk);
        bus.humidity = new_hum;
      end
      n = 0;
      while (exp_active && n < exp_q.size() + 20) begin @(negedge clk); n++; end
      check("frame_in_time", 64'(exp_active), 64'd0);
      exp_active = 0;
    end
    repeat ($urandom_range(4, 10)) @(negedge clk);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int fd0;
    int n;
    int falls;
    logic prev;
    bit saw_short, drove, busy_hi, saw_ss;
    bus.humidity = '0; bus.temperature = '0; bus.corrupt_checksum = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_line", 64'(dht11_line), 64'd1);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_start_seen", 64'(bus.start_seen), 64'd0);
    check("reset_short_start", 64'(bus.short_start), 64'd0);
    check("reset_frame_done", 64'(bus.frame_done), 64'd0);
    check("reset_frame_count", 64'(bus.frame_count), 64'd0);
    rst = 1'b0; model_count = 8'd0;
    repeat (5) @(negedge clk);

    run_frame(16'h3700, 16'h1A05, 1'b0, 40, 1'b0, 16'h0);
    check("frame1_bytes", 64'(last_decoded), 64'h37_00_1A_05_56);
    check("frame1_count", 64'(bus.frame_count), 64'd1);

    // Short host pulse
    host_low = 1'b1;
    repeat (6) @(negedge clk);
    host_low = 1'b0;
    saw_short = 0; drove = 0; busy_hi = 0; saw_ss = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.short_start === 1'b1) saw_short = 1;
      if (dht11_line !== 1'b1) drove = 1;
      if (bus.busy !== 1'b0) busy_hi = 1;
      if (bus.start_seen !== 1'b0) saw_ss = 1;
    end
    check("short_start_pulse", 64'(saw_short), 64'd1);
    check("short_line_driven", 64'(drove), 64'd0);
    check("short_busy", 64'(busy_hi), 64'd0);
    check("short_no_start_seen", 64'(saw_ss), 64'd0);

    run_frame(16'hFFFF, 16'hFF00, 1'b0, 25, 1'b0, 16'h0);
    check("cks_fd", 64'(last_decoded), 64'hFF_FF_FF_00_FD);
    run_frame(16'hFFFF, 16'hFF00, 1'b1, 25, 1'b0, 16'h0);
    check("cks_fc", 64'(last_decoded), 64'hFF_FF_FF_00_FC);

    run_frame(16'h1000, 16'h2233, 1'b0, 25, 1'b1, 16'h2000);
    check("snapshot_hum_byte", 64'(last_decoded[39:32]), 64'h10);

    for (int i = 0; i < 6; i++) begin
      run_frame(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                int'($urandom_range(16, 30)), 1'b0, 16'h0);
    end

    // Reset while bit index 20 is being driven low
    bus.humidity = 16'($urandom); bus.temperature = 16'($urandom);
    host_low = 1'b1;
    repeat (24) @(negedge clk);
    host_low = 1'b0;
    falls = 0; prev = 1'b1; n = 0;
    while (falls < 21 && n < 2000) begin
      @(negedge clk); n++;
      if (prev === 1'b1 && dht11_line === 1'b0) falls++;
      prev = dht11_line;
    end
    check("reach_bit20", 64'(falls), 64'd21);
    check("bit20_low", 64'(dht11_line), 64'd0);
    fd0 = fd_seen;
    rst = 1'b1;
    @(negedge clk);
    check("rst_line_released", 64'(dht11_line), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_frame_count", 64'(bus.frame_count), 64'd0);
    rst = 1'b0; model_count = 8'd0;
    repeat (20) @(negedge clk);
    check("rst_no_frame_done", 64'(fd_seen - fd0), 64'd0);
    check("rst_idle_busy", 64'(bus.busy), 64'd0);

    run_frame(16'h4521, 16'h1703, 1'b0, 30, 1'b0, 16'h0);
    check("post_rst_bytes", 64'(last_decoded), 64'h45_21_17_03_80);
    check("post_rst_count", 64'(bus.frame_count), 64'd1);

    // Back-to-back frames up to the wrap
    for (int i = 0; i < 255; i++) begin
      run_frame(16'h0000, 16'h0000, 1'($urandom_range(0, 1)),
                int'($urandom_range(16, 24)), 1'b0, 16'h0);
    end
    check("wrap_count", 64'(bus.frame_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
